// File: rtl/fpga_ram_ctrl_pkg.sv
// Shared types for the 32-entry 3R/1W LUT-RAM front-end.
package fpga_ram_ctrl_pkg;
  localparam int unsigned DEPTH = 32;
  typedef logic [4:0] ram_addr_t;
  typedef enum logic {INIT, RUN} ctrl_state_e;
endpackage

// File: rtl/fpga_ram_rd_fwd.sv
// One read port: INIT masking plus optional same-cycle write bypass.
// Bypass is enabled by defining FPGA_RAM_WR_BYPASS_EN.
module fpga_ram_rd_fwd
  import fpga_ram_ctrl_pkg::*;
#(
  parameter int unsigned         WIDTH    = 32,
  parameter logic [WIDTH-1:0]    INIT_VAL = '0
) (
  input  logic [$bits(ram_addr_t)-1:0] raddr,
  input  logic [WIDTH-1:0]             ram_dout,
  input  logic                         init,
  input  logic                         hit_valid,
  input  logic [$bits(ram_addr_t)-1:0] hit_addr,
  input  logic [WIDTH-1:0]             hit_data,
  output logic [WIDTH-1:0]             rdata
);

`ifdef FPGA_RAM_WR_BYPASS_EN
  always_comb begin
    if (init)
      rdata = INIT_VAL;
    else if (hit_valid && (hit_addr == raddr))
      rdata = hit_data;
    else
      rdata = ram_dout;
  end
`else
  logic unused_hit;
  assign unused_hit = &{1'b0, hit_valid, hit_addr, hit_data, raddr};

  always_comb begin
    rdata = init ? INIT_VAL : ram_dout;
  end
`endif

endmodule

// File: rtl/fpga_ram_3r1w_init_ctrl.sv
// Clear sequencer and write-port arbiter for a 32x3R1W LUT-RAM.
// Optional same-cycle read bypass: define FPGA_RAM_WR_BYPASS_EN.
module fpga_ram_3r1w_init_ctrl
  import fpga_ram_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             init_busy,
  input  logic             wr_valid,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic [4:0]       raddr0,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic [4:0]       ram_addr0,
  output logic [4:0]       ram_addr1,
  output logic [4:0]       ram_addr2,
  output logic [4:0]       ram_addrw,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_wea,
  input  logic [WIDTH-1:0] ram_dout0,
  input  logic [WIDTH-1:0] ram_dout1,
  input  logic [WIDTH-1:0] ram_dout2
);

  ctrl_state_e state, state_next;
  ram_addr_t   cnt, cnt_next;
  logic        wr_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are gated by rst directly so the RAM is never written while reset is held.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_busy  = 1'b1;
    wr_ready   = 1'b0;
    wr_accept  = 1'b0;
    ram_wea    = 1'b0;
    ram_addrw  = cnt;
    ram_din    = INIT_VAL;
    if (!rst) begin
      unique case (state)
        INIT: begin
          ram_wea  = 1'b1;
          cnt_next = cnt + 1'b1;
          if (cnt == ram_addr_t'(DEPTH - 1))
            state_next = RUN;
        end
        RUN: begin
          init_busy = 1'b0;
          wr_ready  = ~clr_req;
          wr_accept = wr_valid & ~clr_req;
          if (clr_req) begin
            state_next = INIT;
            cnt_next   = '0;
          end else if (wr_accept) begin
            ram_wea   = 1'b1;
            ram_addrw = wr_addr;
            ram_din   = wr_data;
          end
        end
      endcase
    end
  end

  assign ram_addr0 = raddr0;
  assign ram_addr1 = raddr1;
  assign ram_addr2 = raddr2;

  fpga_ram_rd_fwd #(.WIDTH(WIDTH), .INIT_VAL(INIT_VAL)) u_rd0 (
    .raddr(raddr0), .ram_dout(ram_dout0), .init(init_busy),
    .hit_valid(wr_accept), .hit_addr(wr_addr), .hit_data(wr_data), .rdata(rdata0)
  );

  fpga_ram_rd_fwd #(.WIDTH(WIDTH), .INIT_VAL(INIT_VAL)) u_rd1 (
    .raddr(raddr1), .ram_dout(ram_dout1), .init(init_busy),
    .hit_valid(wr_accept), .hit_addr(wr_addr), .hit_data(wr_data), .rdata(rdata1)
  );

  fpga_ram_rd_fwd #(.WIDTH(WIDTH), .INIT_VAL(INIT_VAL)) u_rd2 (
    .raddr(raddr2), .ram_dout(ram_dout2), .init(init_busy),
    .hit_valid(wr_accept), .hit_addr(wr_addr), .hit_data(wr_data), .rdata(rdata2)
  );

endmodule

// File: tb/tb_fpga_ram_3r1w_init_ctrl.sv
// Bench for fpga_ram_3r1w_init_ctrl: LUT-RAM model, cycle-level reference model, directed scenarios.
module tb_fpga_ram_3r1w_init_ctrl;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] IV = '0;

  logic         clk = 1'b0;
  logic         rst, clr_req, wr_valid;
  logic [4:0]   wr_addr, raddr0, raddr1, raddr2;
  logic [W-1:0] wr_data;
  logic         init_busy, wr_ready, ram_wea;
  logic [W-1:0] rdata0, rdata1, rdata2, ram_din, ram_dout0, ram_dout1, ram_dout2;
  logic [4:0]   ram_addr0, ram_addr1, ram_addr2, ram_addrw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_ram_3r1w_init_ctrl #(.WIDTH(W), .INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(init_busy),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
    .ram_addr0(ram_addr0), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_addrw(ram_addrw), .ram_din(ram_din), .ram_wea(ram_wea),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2)
  );

  // The LUT-RAM itself: async read, clocked write, no reset.
  logic [W-1:0] ram [32];
  always @(posedge clk) if (ram_wea) ram[ram_addrw] <= ram_din;
  assign ram_dout0 = ram[ram_addr0];
  assign ram_dout1 = ram[ram_addr1];
  assign ram_dout2 = ram[ram_addr2];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef FPGA_RAM_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference model: a golden memory plus "how many entries the clear has covered".
  logic [W-1:0] gmem [32];
  int  clear_pos = 0;
  bit  armed = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e_rd [3];
    logic [4:0]   ra [3];
    logic [W-1:0] rd [3];
    bit acc;
    ra = '{raddr0, raddr1, raddr2};
    rd = '{rdata0, rdata1, rdata2};
    if (rst) armed = 1'b1;
    if (armed) begin
      chk("m_addr0", {27'd0, ram_addr0}, {27'd0, raddr0});
      chk("m_addr1", {27'd0, ram_addr1}, {27'd0, raddr1});
      chk("m_addr2", {27'd0, ram_addr2}, {27'd0, raddr2});
      if (rst) begin
        chk("m_busy", W'(init_busy), W'(1));
        chk("m_ready", W'(wr_ready), W'(0));
        chk("m_wea", W'(ram_wea), W'(0));
        for (int unsigned i = 0; i < 3; i++) chk("m_rdata", rd[i], IV);
        clear_pos = 0;
      end else if (clear_pos < 32) begin
        chk("m_busy", W'(init_busy), W'(1));
        chk("m_ready", W'(wr_ready), W'(0));
        chk("m_wea", W'(ram_wea), W'(1));
        chk("m_addrw", W'(ram_addrw), W'(clear_pos));
        chk("m_din", ram_din, IV);
        for (int unsigned i = 0; i < 3; i++) chk("m_rdata", rd[i], IV);
        gmem[clear_pos] = IV;
        clear_pos++;
      end else begin
        acc = wr_valid && !clr_req;
        chk("m_busy", W'(init_busy), W'(0));
        chk("m_ready", W'(wr_ready), W'(!clr_req));
        chk("m_wea", W'(ram_wea), W'(acc));
        if (acc) begin
          chk("m_addrw", W'(ram_addrw), W'(wr_addr));
          chk("m_din", ram_din, wr_data);
        end
        for (int unsigned i = 0; i < 3; i++) begin
          e_rd[i] = (BYPASS && acc && wr_addr == ra[i]) ? wr_data : gmem[ra[i]];
          chk("m_rdata", rd[i], e_rd[i]);
        end
        if (clr_req) clear_pos = 0;
        else if (acc) gmem[wr_addr] = wr_data;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs the clear to completion, optionally pulsing clr_req at one step; returns the busy-cycle count.
  task automatic count_busy(input int clr_at, output int n);
    n = 0;
    while (init_busy && n < 200) begin
      clr_req = (n == clr_at);
      #1;
      chk("clr_addrw", W'(ram_addrw), W'(n));
      cyc();
      n++;
    end
    clr_req = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; clr_req = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    raddr0 = '0; raddr1 = '0; raddr2 = '0;
    cyc(); cyc();
    #1;
    chk("rst_busy", W'(init_busy), W'(1));
    chk("rst_wea", W'(ram_wea), W'(0));
    chk("rst_ready", W'(wr_ready), W'(0));

    // 1: reset release, 32 clear writes, then RUN
    rst = 1'b0;
    count_busy(-1, n);
    chk("s1_clear_len", W'(n), W'(32));
    #1;
    chk("s1_ready", W'(wr_ready), W'(1));
    for (int unsigned a = 0; a < 32; a++) begin
      raddr0 = 5'(a); raddr1 = 5'(31 - a); raddr2 = 5'(a ^ 5);
      #1;
      chk("s1_read", rdata0, IV);
      cyc();
    end

    // 2: write then read on all ports
    write(5'd5, 32'hDEADBEEF);
    raddr0 = 5'd5; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    chk("s2_rd0", rdata0, 32'hDEADBEEF);
    chk("s2_rd1", rdata1, 32'hDEADBEEF);
    chk("s2_rd2", rdata2, 32'hDEADBEEF);
    raddr2 = 5'd6;
    #1;
    chk("s2_rd6", rdata2, IV);
    cyc();

    // 3: same-cycle read-after-write
    write(5'd7, 32'h1);
    raddr1 = 5'd7; raddr0 = 5'd5;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h2;
    #1;
    chk("s3_raw", rdata1, BYPASS ? 32'h2 : 32'h1);
    chk("s3_other", rdata0, 32'hDEADBEEF);
    cyc();
    wr_valid = 1'b0;
    #1;
    chk("s3_next", rdata1, 32'h2);
    cyc();

    // 4: fill, then clear with a competing write
    for (int unsigned a = 0; a < 32; a++) write(5'(a), 32'h1000 + a);
    raddr0 = 5'd3; raddr1 = 5'd9;
    #1;
    chk("s4_filled", rdata1, 32'h1009);
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    #1;
    chk("s4_ready", W'(wr_ready), W'(0));
    chk("s4_wea", W'(ram_wea), W'(0));
    cyc();
    clr_req = 1'b0; wr_valid = 1'b0;
    #1;
    chk("s4_mask", rdata0, IV);
    count_busy(-1, n);
    chk("s4_clear_len", W'(n), W'(32));
    #1;
    chk("s4_rd3", rdata0, IV);
    chk("s4_rd9", rdata1, IV);
    cyc();

    // 5: reset mid-INIT at cnt=17
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int unsigned i = 0; i < 17; i++) cyc();
    #1;
    chk("s5_cnt17", W'(ram_addrw), W'(17));
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    count_busy(-1, n);
    chk("s5_clear_len", W'(n), W'(32));
    #1;
    chk("s5_run", W'(wr_ready), W'(1));
    cyc();

    // 6: clr_req during INIT is ignored
    rst = 1'b1; cyc(); rst = 1'b0;
    count_busy(10, n);
    chk("s6_clear_len", W'(n), W'(32));
    #1;
    chk("s6_busy", W'(init_busy), W'(0));
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
